// File: rtl/sample_msg_demux.sv
// Splits a mixed sample/message stream into a sample port and N_CHANNELS message
// destinations selected by the header channel field; invalid channels are dropped.
module sample_msg_demux #(
    parameter int WIDTH      = 32,
    parameter int LEN_WIDTH  = 10,
    parameter int CHAN_WIDTH = 2,
    parameter int N_CHANNELS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_nd,
    input  logic                  err_clear,
    output logic [WIDTH-1:0]      out_samples,
    output logic                  out_samples_nd,
    output logic [WIDTH-1:0]      out_msg,
    output logic [N_CHANNELS-1:0] out_msg_nd,
    output logic                  out_msg_last,
    output logic [1:0]            error,
    output logic [15:0]           msg_count
);
    localparam int NCODE = 2 ** CHAN_WIDTH;

    // Lookup of which channel codes map to a real destination.
    function automatic logic [NCODE-1:0] chan_ok_mask();
        logic [NCODE-1:0] m;
        for (int i = 0; i < NCODE; i++) m[i] = (i < N_CHANNELS);
        return m;
    endfunction
    localparam logic [NCODE-1:0] CHAN_OK = chan_ok_mask();

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t                r_state, w_state;
    logic [LEN_WIDTH-1:0]  r_rem, w_rem;
    logic [CHAN_WIDTH-1:0] r_chan, w_chan;
    logic [WIDTH-1:0]      w_samples, w_msg;
    logic                  w_samples_nd, w_last;
    logic [N_CHANNELS-1:0] w_msg_nd;
    logic [1:0]            w_error;
    logic [15:0]           w_count;

    logic                  w_hdr;
    logic [LEN_WIDTH-1:0]  w_hlen;
    logic [CHAN_WIDTH-1:0] w_hchan;

    assign w_hdr   = in_data[WIDTH-1];
    assign w_hlen  = in_data[WIDTH-2 -: LEN_WIDTH];
    assign w_hchan = in_data[WIDTH-2-LEN_WIDTH -: CHAN_WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_rem          <= '0;
            r_chan         <= '0;
            out_samples    <= '0;
            out_samples_nd <= 1'b0;
            out_msg        <= '0;
            out_msg_nd     <= '0;
            out_msg_last   <= 1'b0;
            error          <= 2'b00;
            msg_count      <= '0;
        end else begin
            r_state        <= w_state;
            r_rem          <= w_rem;
            r_chan         <= w_chan;
            out_samples    <= w_samples;
            out_samples_nd <= w_samples_nd;
            out_msg        <= w_msg;
            out_msg_nd     <= w_msg_nd;
            out_msg_last   <= w_last;
            error          <= w_error;
            msg_count      <= w_count;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_rem        = r_rem;
        w_chan       = r_chan;
        w_samples    = out_samples;
        w_samples_nd = 1'b0;
        w_msg        = out_msg;
        w_msg_nd     = '0;
        w_last       = 1'b0;
        // Clear first so a same-cycle error event below wins.
        w_error      = err_clear ? 2'b00 : error;
        w_count      = msg_count;

        if (in_nd) begin
            if (w_hdr) begin
                if (r_state != IDLE) w_error[0] = 1'b1;
                if (CHAN_OK[w_hchan]) begin
                    w_msg = in_data;
                    for (int c = 0; c < N_CHANNELS; c++)
                        w_msg_nd[c] = (w_hchan == CHAN_WIDTH'(c));
                    if (w_hlen == '0) begin
                        w_last  = 1'b1;
                        w_count = msg_count + 16'd1;
                        w_state = IDLE;
                    end else begin
                        w_chan  = w_hchan;
                        w_rem   = w_hlen;
                        w_state = FWD;
                    end
                end else begin
                    w_error[1] = 1'b1;
                    w_rem      = w_hlen;
                    w_state    = (w_hlen == '0) ? IDLE : DROP;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        w_samples    = in_data;
                        w_samples_nd = 1'b1;
                    end
                    FWD: begin
                        w_msg = in_data;
                        for (int c = 0; c < N_CHANNELS; c++)
                            w_msg_nd[c] = (r_chan == CHAN_WIDTH'(c));
                        w_rem = r_rem - 1'b1;
                        if (r_rem == LEN_WIDTH'(1)) begin
                            w_last  = 1'b1;
                            w_count = msg_count + 16'd1;
                            w_state = IDLE;
                        end
                    end
                    DROP: begin
                        w_rem = r_rem - 1'b1;
                        if (r_rem == LEN_WIDTH'(1)) w_state = IDLE;
                    end
                    default: w_state = IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/sample_msg_demux.md
Name: sample_msg_demux

Overview:
Successor to the single-channel sample/message splitter. Splits one mixed input stream into a sample stream and up to N_CHANNELS message destinations, using a channel field in the message header. Adds an end-of-message flag, drop handling for invalid channels, classified sticky errors with a clear input, and a delivered-message counter. Sits directly after the input stream source and feeds the per-block message handlers.

Parameters:
WIDTH, 32, word width of input, samples and message words.
LEN_WIDTH, 10, width of the header length field.
CHAN_WIDTH, 2, width of the header channel field.
N_CHANNELS, 4, number of message destinations; must be ≤ 2^CHAN_WIDTH. Also requires LEN_WIDTH+CHAN_WIDTH ≤ WIDTH-1.

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
in_data  in  WIDTH  input word
in_nd  in  1  in_data valid this cycle
err_clear  in  1  clears sticky error bits
out_samples  out  WIDTH  sample word
out_samples_nd  out  1  out_samples valid
out_msg  out  WIDTH  message word (header or content), shared by all channels
out_msg_nd  out  N_CHANNELS  one-hot; bit c set = out_msg is valid for channel c
out_msg_last  out  1  out_msg is the final word of its message
error  out  2  sticky; [0] header arrived mid-message, [1] header channel ≥ N_CHANNELS
msg_count  out  16  count of completely delivered messages; wraps at 2^16

Behaviour:
- Header: in_data[WIDTH-1]=1. length L = in_data[WIDTH-2 -: LEN_WIDTH]; channel C = in_data[WIDTH-2-LEN_WIDTH -: CHAN_WIDTH]. L content words (MSB=0) follow the header. Samples have MSB=0 outside a message.
- Registered outputs; latency exactly 1 cycle from an in_nd word to its output strobe. Every *_nd output is a single-cycle pulse and is 0 in any cycle after in_nd=0.
- Reset values: out_samples_nd=0, out_msg_nd=0, out_msg_last=0, error=0, msg_count=0, state=IDLE, position counter=0. Data outputs are don't-care at reset.
- States: IDLE, FWD, DROP. Position counter is LEN_WIDTH wide and tracks content words remaining.
- IDLE, MSB=0: pass the word to out_samples and pulse out_samples_nd.
- IDLE, header, C < N_CHANNELS: emit the header on out_msg with out_msg_nd[C]=1.
  - If L=0: assert out_msg_last, increment msg_count, stay in IDLE.
  - Otherwise latch C and remaining=L, then go to FWD.
- IDLE, header, C ≥ N_CHANNELS: set error[1] and emit no output.
  - If L=0: stay in IDLE.
  - Otherwise set remaining=L and go to DROP.
- FWD, MSB=0: emit the word with out_msg_nd[latched C]=1 and decrement remaining.
  - When remaining reaches 0: assert out_msg_last, increment msg_count, return to IDLE.
- DROP, MSB=0: discard the word and decrement remaining. When remaining reaches 0, return to IDLE.
- FWD or DROP, header received: set error[0] and abandon the current message (no out_msg_last, no count increment). Then process the new header exactly as in IDLE, in the same cycle.
- err_clear=1 clears error on that clock edge. If an error event occurs in the same cycle, the event wins and the bit ends up set.
- Reset mid-message returns to IDLE. The next MSB=0 word after reset is treated as a sample.
- in_nd=0 never changes state, remaining, error or msg_count.

Test Plan:
(WIDTH=32, LEN_WIDTH=10, CHAN_WIDTH=2, N_CHANNELS=3 for all scenarios.)
1. Samples pass-through: 0x00000005, 0x00000007 with in_nd=1 → out_samples_nd pulses one cycle later with the same values; out_msg_nd=0; error=0.
2. Delivered message: header 0x80480000 (C=1, L=2), then 0x11, then 0x22 → out_msg_nd=3'b010 for all three words; out_msg_last only on 0x22; msg_count=1. A following 0x33 appears on out_samples.
3. Zero-length message: 0x80000000 → out_msg_nd=3'b001 with out_msg_last=1 in the same cycle; msg_count increments; state stays IDLE.
4. Invalid channel: 0x80380000 (C=3, L=1), then 0x44, then 0x55 → no strobe for 0x44; error=2'b10; 0x55 appears on out_samples.
5. Truncated message: 0x80480000, 0x11, then 0x80000000 → error[0]=1; msg_count increments only for the zero-length message (+1 total); its header appears on out_msg_nd=3'b001 with out_msg_last=1. Then err_clear=1 → error=0 on the next cycle.
6. Gaps and reset: the scenario 2 message with in_nd=0 cycles interleaved → identical output sequence. Assert rst_n=0 for one cycle after 0x11 → all outputs return to reset values, and a following 0x22 appears on out_samples.
